quad_demux_1to2_reg: RTL and testbench
======================================

Name: quad_demux_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer for 4-bit nibbles. It is the receive-side counterpart of the quad 2-to-1 multiplexer.
- One input nibble stream carries select S and active-low enable E. Each nibble is steered to output channel A (S=0) or channel B (S=1).
- Each output channel holds one registered slot with a valid/ready handshake.
- Sits between the shared nibble bus and two independent consumers. Counts delivered and discarded beats for debug.

Parameters:
- WIDTH, 4: data width of D, YA and YB.
- CNT_W, 8: width of the per-channel delivered counters and the discard counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  WIDTH  input nibble.
- S  input  1  channel select: 0 = A, 1 = B.
- E  input  1  active-low enable: 0 = route, 1 = discard.
- in_valid  input  1  D/S/E qualify a beat this cycle.
- in_ready  output  1  beat is accepted this cycle when in_valid & in_ready.
- YA  output  WIDTH  channel A data.
- a_valid  output  1  YA holds a beat.
- a_ready  input  1  channel A consumer accepts.
- YB  output  WIDTH  channel B data.
- b_valid  output  1  YB holds a beat.
- b_ready  input  1  channel B consumer accepts.
- a_cnt  output  CNT_W  beats delivered on A (a_valid & a_ready); wraps.
- b_cnt  output  CNT_W  beats delivered on B; wraps.
- disc_cnt  output  CNT_W  beats accepted with E=1; saturates at all-ones.

Behaviour:
- Reset (rst=1 at an edge): YA=YB=0, a_valid=b_valid=0, a_cnt=b_cnt=disc_cnt=0. rst overrides every other event in that cycle.
- Slot state per channel: EMPTY or FULL, reflected directly on x_valid. Transitions:
  - EMPTY -> FULL on a fill.
  - FULL -> EMPTY on a drain without a fill.
  - FULL -> FULL on a simultaneous drain and fill, or when stalled.
- in_ready is combinational from inputs and current state:
  - E=1: in_ready=1 (discard is always possible).
  - E=0, S=0: in_ready = !a_valid | a_ready.
  - E=0, S=1: in_ready = !b_valid | b_ready.
  - in_ready does not depend on in_valid.
- Fill A: in_valid & in_ready & !E & !S. YA<=D and a_valid<=1 at the next edge. Latency from input beat to a_valid is 1 cycle. Fill B is symmetric with S=1.
- Drain: x_valid & x_ready. The slot empties at the next edge unless it is refilled in the same cycle. On a simultaneous drain and fill, x_valid stays 1 and Yx takes the new D (full throughput, no bubble).
- A stalled slot (x_valid & !x_ready) holds Yx stable. A beat targeting a stalled slot is not accepted; the other channel keeps draining independently.
- Discard: in_valid & E=1. No slot changes. disc_cnt increments unless it is all-ones.
- Counters: a_cnt increments on each A drain and wraps from all-ones to 0. b_cnt is the same for B. A fill and a drain of the same channel in one cycle count exactly one delivery.
- Data held in YA/YB is never modified except by a fill or by reset.
- No combinational path from D to YA/YB.

Decomposition:
- Shared package quad_mux_pkg: WIDTH default constant, CNT_W default constant, and localparams SEL_A=1'b0, SEL_B=1'b1, EN_ACTIVE=1'b0.
- One natural sub-module, demux_slot: one-deep registered slot with fill/drain logic, its output register, valid flag, delivered counter, and local ready (!valid | ready). It is instantiated twice.
- Top level holds in_ready selection, fill decode and disc_cnt.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, D=4'hF -> a_valid=b_valid=0, YA=YB=0, all counters 0, nothing captured.
- Route A: E=0, S=0, D=4'b1010, in_valid=1, a_ready=0 for 1 cycle -> next cycle a_valid=1, YA=4'b1010, b_valid=0. Offering a second S=0 beat with a_ready=0 gives in_ready=0.
- Route B with stall: E=0, S=1, D=4'b0011, b_ready=0 for 3 cycles -> YB=4'b0011 held; b_cnt=0. Raise b_ready for 1 cycle -> b_valid=0 and b_cnt=1.
- Throughput: a_ready=1, stream S=0 beats 4'h1, 4'h2, 4'h3 back-to-back -> in_ready stays 1, YA=1,2,3 on consecutive cycles, a_cnt=3.
- Discard and saturation: E=1, S=0, D=4'b0000, in_valid=1 for 300 cycles -> in_ready=1, a_valid=0, disc_cnt=255.
- Independence: A stalled with 4'h5 while B streams 4'h6, 4'h7 with b_ready=1 -> B delivers both, YA stays 4'h5, an S=0 beat is refused until a_ready=1.

Source files
------------

// File: rtl/quad_mux_pkg.sv
// Shared constants and types for the quad nibble mux/demux family.
// Provides default widths, select/enable encodings and the per-slot state type.
package quad_mux_pkg;

    localparam int unsigned QM_WIDTH = 4;   // default nibble width
    localparam int unsigned QM_CNT_W = 8;   // default debug counter width

    localparam logic SEL_A     = 1'b0;      // S value steering to channel A
    localparam logic SEL_B     = 1'b1;      // S value steering to channel B
    localparam logic EN_ACTIVE = 1'b0;      // E value that routes (active-low enable)

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : quad_mux_pkg

// File: rtl/quad_demux_1to2_reg_slot.sv
// demux_slot: one-deep registered output slot with valid/ready handshake.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   fill_i          load data_i into the slot this cycle (caller guarantees can_fill_c_o)
//   data_i          incoming nibble
//   ready_i         downstream consumer accepts
//   data_o          registered slot data
//   valid_o         slot holds a beat (EMPTY/FULL state)
//   cnt_o           wrapping count of delivered beats
//   can_fill_c_o    combinational: slot can take a beat this cycle
module demux_slot
    import quad_mux_pkg::*;
#(
    parameter int unsigned WIDTH = QM_WIDTH,
    parameter int unsigned CNT_W = QM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             can_fill_c_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    assign valid_o      = (state_q == SLOT_FULL);
    assign drain        = valid_o & ready_i;
    // Full-throughput: a draining slot can be refilled in the same cycle.
    assign can_fill_c_o = !valid_o | ready_i;

    // Next-state for data and delivered counter.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (fill_i) begin
            data_d = data_i;
        end
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot state machine and registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            case (state_q)
                SLOT_EMPTY: if (fill_i) state_q <= SLOT_FULL;
                SLOT_FULL:  if (drain && !fill_i) state_q <= SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;

endmodule : demux_slot

// File: rtl/quad_demux_1to2_reg.sv
// quad_demux_1to2_reg: registered 1-to-2 nibble demultiplexer with debug counters.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   D, S, E, in_valid     input beat: data, select (0=A,1=B), active-low enable, qualifier
//   in_ready              combinational: beat accepted when in_valid & in_ready
//   YA, a_valid, a_ready  channel A output slot and handshake
//   YB, b_valid, b_ready  channel B output slot and handshake
//   a_cnt, b_cnt          wrapping delivered-beat counters
//   disc_cnt              saturating count of discarded (E=1) beats
module quad_demux_1to2_reg
    import quad_mux_pkg::*;
#(
    parameter int unsigned WIDTH = QM_WIDTH,
    parameter int unsigned CNT_W = QM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    input  logic             E,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] YA,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] YB,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic [CNT_W-1:0] disc_cnt
);

    logic             a_can_fill, b_can_fill;
    logic             route, fill_a, fill_b, discard;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;

    assign route = (E == EN_ACTIVE);

    // Discards never stall; routed beats wait on the targeted slot only.
    always_comb begin
        in_ready = 1'b1;
        if (route) begin
            in_ready = (S == SEL_A) ? a_can_fill : b_can_fill;
        end
    end

    assign fill_a  = in_valid & in_ready & route & (S == SEL_A);
    assign fill_b  = in_valid & in_ready & route & (S == SEL_B);
    assign discard = in_valid & !route;

    // Saturating discard counter.
    always_comb begin
        disc_cnt_d = disc_cnt_q;
        if (discard && (disc_cnt_q != {CNT_W{1'b1}})) begin
            disc_cnt_d = disc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disc_cnt_q <= '0;
        end else begin
            disc_cnt_q <= disc_cnt_d;
        end
    end

    assign disc_cnt = disc_cnt_q;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (fill_a),
        .data_i       (D),
        .ready_i      (a_ready),
        .data_o       (YA),
        .valid_o      (a_valid),
        .cnt_o        (a_cnt),
        .can_fill_c_o (a_can_fill)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (fill_b),
        .data_i       (D),
        .ready_i      (b_ready),
        .data_o       (YB),
        .valid_o      (b_valid),
        .cnt_o        (b_cnt),
        .can_fill_c_o (b_can_fill)
    );

endmodule : quad_demux_1to2_reg

// File: tb/tb_quad_demux_1to2_reg.sv
// Directed self-checking bench for quad_demux_1to2_reg.
module tb_quad_demux_1to2_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic       S, E, in_valid, in_ready;
    logic [3:0] YA, YB;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [7:0] a_cnt, b_cnt, disc_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    quad_demux_1to2_reg dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .S        (S),
        .E        (E),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .YA       (YA),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .YB       (YB),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
        .disc_cnt (disc_cnt)
    );

    // Advance one rising edge; inputs driven afterwards are stable before the next edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a live beat on the bus: nothing must be captured.
        rst = 1'b1; in_valid = 1'b1; D = 4'hF; S = 1'b0; E = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        step(); step();
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_YA", 32'(YA), 32'd0);
        check("rst_YB", 32'(YB), 32'd0);
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_cnt", 32'(b_cnt), 32'd0);
        check("rst_disc_cnt", 32'(disc_cnt), 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        // Route A, then a second A beat is refused while A is stalled.
        E = 1'b0; S = 1'b0; D = 4'b1010; in_valid = 1'b1; #1;
        check("a_empty_in_ready", 32'(in_ready), 32'd1);
        step();
        D = 4'hC; #1;
        check("a_fill_valid", 32'(a_valid), 32'd1);
        check("a_fill_YA", 32'(YA), 32'hA);
        check("a_fill_b_valid", 32'(b_valid), 32'd0);
        check("a_stall_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; #1;
        check("in_ready_no_valid_dep", 32'(in_ready), 32'd0);
        step();
        check("a_refused_YA", 32'(YA), 32'hA);

        // Route B with a 3-cycle stall, then one drain.
        S = 1'b1; D = 4'b0011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b_fill_valid", 32'(b_valid), 32'd1);
        check("b_fill_YB", 32'(YB), 32'h3);
        step(); step();
        check("b_stall_YB", 32'(YB), 32'h3);
        check("b_stall_valid", 32'(b_valid), 32'd1);
        check("b_stall_cnt", 32'(b_cnt), 32'd0);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        check("b_drain_valid", 32'(b_valid), 32'd0);
        check("b_drain_cnt", 32'(b_cnt), 32'd1);

        // Drain the held A beat, then stream three beats back to back.
        a_ready = 1'b1;
        step();
        check("a_drain_valid", 32'(a_valid), 32'd0);
        check("a_drain_cnt", 32'(a_cnt), 32'd1);
        S = 1'b0; in_valid = 1'b1; D = 4'h1; #1;
        check("tp_in_ready1", 32'(in_ready), 32'd1);
        step();
        check("tp_YA1", 32'(YA), 32'h1);
        check("tp_cnt1", 32'(a_cnt), 32'd1);
        D = 4'h2; #1;
        check("tp_in_ready2", 32'(in_ready), 32'd1);
        step();
        check("tp_YA2", 32'(YA), 32'h2);
        check("tp_valid2", 32'(a_valid), 32'd1);
        check("tp_cnt2", 32'(a_cnt), 32'd2);
        D = 4'h3; #1;
        check("tp_in_ready3", 32'(in_ready), 32'd1);
        step();
        check("tp_YA3", 32'(YA), 32'h3);
        check("tp_cnt3", 32'(a_cnt), 32'd3);
        in_valid = 1'b0;
        step();
        check("tp_end_valid", 32'(a_valid), 32'd0);
        check("tp_end_cnt", 32'(a_cnt), 32'd4);
        a_ready = 1'b0;

        // Discard stream: counts up, then saturates at 255.
        E = 1'b1; S = 1'b0; D = 4'h0; in_valid = 1'b1; #1;
        check("disc_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("disc_cnt10", 32'(disc_cnt), 32'd10);
        for (int i = 0; i < 290; i++) step();
        check("disc_sat", 32'(disc_cnt), 32'd255);
        check("disc_a_valid", 32'(a_valid), 32'd0);
        check("disc_b_valid", 32'(b_valid), 32'd0);
        check("disc_a_cnt", 32'(a_cnt), 32'd4);
        in_valid = 1'b0;

        // Independence: A stalled with 5 while B streams 6, 7.
        E = 1'b0; S = 1'b0; D = 4'h5; in_valid = 1'b1;
        step();
        check("ind_YA5", 32'(YA), 32'h5);
        S = 1'b1; D = 4'h6; b_ready = 1'b1; #1;
        check("ind_b_in_ready", 32'(in_ready), 32'd1);
        step();
        check("ind_YB6", 32'(YB), 32'h6);
        D = 4'h7;
        step();
        check("ind_YB7", 32'(YB), 32'h7);
        check("ind_b_cnt2", 32'(b_cnt), 32'd2);
        in_valid = 1'b0;
        step();
        check("ind_b_empty", 32'(b_valid), 32'd0);
        check("ind_b_cnt3", 32'(b_cnt), 32'd3);
        check("ind_YA_held", 32'(YA), 32'h5);
        check("ind_a_held_valid", 32'(a_valid), 32'd1);
        S = 1'b0; D = 4'h8; in_valid = 1'b1; #1;
        check("ind_a_refused", 32'(in_ready), 32'd0);
        step();
        check("ind_YA_still5", 32'(YA), 32'h5);
        in_valid = 1'b0; E = 1'b1; #1;
        check("ind_disc_ready_stalled", 32'(in_ready), 32'd1);
        E = 1'b0; a_ready = 1'b1; in_valid = 1'b1; #1;
        check("ind_a_ready_now", 32'(in_ready), 32'd1);
        step();
        check("ind_YA8", 32'(YA), 32'h8);
        check("ind_a_cnt5", 32'(a_cnt), 32'd5);
        in_valid = 1'b0;
        step();
        check("ind_a_empty", 32'(a_valid), 32'd0);
        check("ind_a_cnt6", 32'(a_cnt), 32'd6);
        check("ind_YA_kept", 32'(YA), 32'h8);

        // Mid-run reset overrides a simultaneous fill and clears everything.
        a_ready = 1'b0; b_ready = 1'b0; S = 1'b1; D = 4'h9; in_valid = 1'b1; rst = 1'b1;
        step();
        check("rst2_b_valid", 32'(b_valid), 32'd0);
        check("rst2_YA", 32'(YA), 32'd0);
        check("rst2_a_cnt", 32'(a_cnt), 32'd0);
        check("rst2_b_cnt", 32'(b_cnt), 32'd0);
        check("rst2_disc", 32'(disc_cnt), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_quad_demux_1to2_reg
